wall_bank_sequencer: RTL and testbench
======================================

Name: wall_bank_sequencer

Overview:
- Owns a bank of N_WALLS wall rectangles for the graphic controller.
- CPU memory-mapped writes land in a shadow bank. A CPU commit request arms a copy into the active bank, and the copy runs at the next vertical-blank rising edge, so no tearing occurs mid-frame.
- The pixel path composites the active walls with fixed priority (lowest index wins) into registered RGB for the VGA mixer.

Parameters:
- N_WALLS, 4, number of wall rectangles (1..8).
- BG_RGB, 24'h000000, colour output when no wall is hit.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- MW_i  in  1  CPU memory write strobe, one write per high cycle
- address_i  in  $clog2(N_WALLS)+3  {wall_idx, field[2:0]}
- data_i  in  32  write data
- commit_i  in  1  single-cycle commit request
- vblank_i  in  1  vertical-blank level from the VGA timing block, synchronous to clk
- x_pos_i  in  32  current pixel x
- y_pos_i  in  32  current pixel y
- RGB_o  out  24  composited pixel colour, registered
- visible_o  out  1  any wall hit, registered
- busy_o  out  1  high in ARMED or COPY
- done_o  out  1  one-cycle pulse when the copy completes
- drop_o  out  1  one-cycle pulse when a write is discarded

Behaviour:
- Field map:
  - 0 = x_min, 1 = x_max, 2 = y_min, 3 = y_max (32-bit each).
  - 4 = colour (data_i[23:0]).
  - 5 = enable (data_i[0]).
  - Fields 6 and 7 are reserved: write ignored, no drop_o.
  - wall_idx >= N_WALLS: write ignored, no drop_o.
- Reset values:
  - All shadow and active bounds = 0, enable = 0, colour = 24'h15688E.
  - RGB_o = BG_RGB, visible_o = 0, busy_o = 0, done_o = 0, drop_o = 0.
  - FSM = IDLE, copy index = 0, vblank edge register = 0.
- FSM:
  - IDLE: commit_i -> ARMED.
  - ARMED: rising edge of vblank_i (registered previous = 0, current = 1) -> COPY, index = 0.
  - COPY: each cycle, active[index] <= shadow[index] and index++. After index N_WALLS-1, go to IDLE and pulse done_o on the following cycle. The copy takes exactly N_WALLS cycles.
- Write rules:
  - In IDLE, MW_i updates the shadow bank on the clock edge.
  - In ARMED or COPY, MW_i is dropped: shadow is unchanged and drop_o pulses the next cycle.
  - MW_i and commit_i in the same IDLE cycle: the write is accepted and included in the commit.
- commit_i while busy_o is high is ignored (no queueing).
- commit_i in IDLE coinciding with a vblank rising edge: the FSM enters ARMED only. That edge is not used; the copy waits for the next rising edge.
- Reset asserted mid-COPY: asynchronous clear to reset values; a partial copy is discarded.
- Hit test per wall:
  - enable & x_min <= x < x_max & y_min <= y < y_max.
  - Comparisons are unsigned, half-open intervals.
  - min >= max gives no hit.
- Compositing:
  - Lowest hit index supplies the colour; otherwise BG_RGB.
  - RGB_o and visible_o are registered: 1-cycle latency from x_pos_i/y_pos_i.
- The pixel path always reads the active bank. During COPY, some walls show new values and others still show old values; this is acceptable because COPY only occurs in blanking.

Optional Feature:
- WALLS_DEFAULT_EN
- Defined: reset loads wall 0 in both the shadow and active banks with x 22..60, y 35..200, colour 24'h15688E, enable = 1. This gives a visible default wall before software runs.
- Undefined: all walls reset disabled, as above.

Decomposition:
- Package walls_pkg:
  - wall_t struct {x_min, x_max, y_min, y_max, colour, en}.
  - Field enum FLD_XMIN..FLD_EN.
  - State enum IDLE/ARMED/COPY.
  - Constants DEFAULT_RGB = 24'h15688E and the default rectangle values.
- Sub-module wall_hit: combinational rectangle test, inputs wall_t and x/y, output hit. Instantiated N_WALLS times.

Test Plan:
- After reset, x = 30, y = 100 -> RGB_o = BG_RGB, visible_o = 0. With WALLS_DEFAULT_EN -> RGB_o = 24'h15688E, visible_o = 1.
- Write wall 1 = (10, 20, 10, 20), colour 24'hFF0000, en = 1, then commit_i, then a vblank rise -> busy_o high for 1 + N_WALLS cycles, then done_o pulse. x = 15, y = 15 -> RGB_o = 24'hFF0000 one cycle later. x = 20, y = 15 -> BG_RGB (exclusive bound).
- Overlap: wall 0 colour 24'h00FF00 and wall 1 colour 24'hFF0000 both cover (15, 15) -> RGB_o = 24'h00FF00.
- MW_i while ARMED -> drop_o pulses; after the commit, the active bank holds the pre-arm value.
- commit_i in the same cycle as a vblank rise -> no copy; the copy occurs at the next vblank rise.
- Assert rst at COPY index 1 (N_WALLS = 4) -> all outputs take reset values immediately (asynchronously); active bank at reset values.

Source files
------------

// File: rtl/walls_pkg.sv
// Shared types and constants for the wall bank sequencer.
// Build macro WALLS_DEFAULT_EN: when defined, wall 0 comes out of reset
// enabled with a default rectangle in both the shadow and active banks.
package walls_pkg;

  // One wall rectangle: half-open bounds [min, max) on each axis.
  typedef struct packed {
    logic [31:0] x_min;
    logic [31:0] x_max;
    logic [31:0] y_min;
    logic [31:0] y_max;
    logic [23:0] colour;
    logic        en;
  } wall_t;

  // Field selector carried in address_i[2:0]; 6 and 7 are reserved.
  typedef enum logic [2:0] {
    FLD_XMIN = 3'd0,
    FLD_XMAX = 3'd1,
    FLD_YMIN = 3'd2,
    FLD_YMAX = 3'd3,
    FLD_COL  = 3'd4,
    FLD_EN   = 3'd5
  } fld_e;

  // Commit sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COPY  = 2'd2
  } state_t;

  localparam logic [23:0] DEFAULT_RGB = 24'h15688E;
  localparam logic [31:0] DEF_X_MIN   = 32'd22;
  localparam logic [31:0] DEF_X_MAX   = 32'd60;
  localparam logic [31:0] DEF_Y_MIN   = 32'd35;
  localparam logic [31:0] DEF_Y_MAX   = 32'd200;

`ifdef WALLS_DEFAULT_EN
  localparam bit DEFAULT_WALL0 = 1'b1;
`else
  localparam bit DEFAULT_WALL0 = 1'b0;
`endif

  // Reset contents of wall slot idx (identical for shadow and active).
  function automatic wall_t reset_wall(input int idx);
    wall_t w;
    w.x_min  = '0;
    w.x_max  = '0;
    w.y_min  = '0;
    w.y_max  = '0;
    w.colour = DEFAULT_RGB;
    w.en     = 1'b0;
    if (DEFAULT_WALL0 && idx == 0) begin
      w.x_min = DEF_X_MIN;
      w.x_max = DEF_X_MAX;
      w.y_min = DEF_Y_MIN;
      w.y_max = DEF_Y_MAX;
      w.en    = 1'b1;
    end
    return w;
  endfunction

endpackage

// File: rtl/wall_hit.sv
// Combinational rectangle hit test: enabled and inside half-open bounds.
// An empty interval (min >= max) can never hit.
module wall_hit
  import walls_pkg::*;
(
  input  wall_t       wall,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        hit
);

  assign hit = wall.en &&
               (x >= wall.x_min) && (x < wall.x_max) &&
               (y >= wall.y_min) && (y < wall.y_max);

endmodule

// File: rtl/wall_bank_sequencer.sv
// Shadow/active wall bank with a vblank-synchronised commit copy and a
// fixed-priority (lowest index wins) pixel compositor.
// Build macro WALLS_DEFAULT_EN (see walls_pkg) selects a default wall 0.
//
// Handshake: MW_i is a one-cycle write strobe accepted only in IDLE; while
// busy_o is high a write to a real field is discarded and drop_o pulses one
// cycle later. commit_i is a one-cycle request honoured only in IDLE; the
// copy starts on the next vblank rising edge seen while ARMED and done_o
// pulses one cycle after the last wall is copied.
module wall_bank_sequencer
  import walls_pkg::*;
#(
  parameter int          N_WALLS = 4,
  parameter logic [23:0] BG_RGB  = 24'h000000
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         MW_i,
  input  logic [$clog2(N_WALLS)+2:0]   address_i,
  input  logic [31:0]                  data_i,
  input  logic                         commit_i,
  input  logic                         vblank_i,
  input  logic [31:0]                  x_pos_i,
  input  logic [31:0]                  y_pos_i,
  output logic [23:0]                  RGB_o,
  output logic                         visible_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         drop_o,
  output state_t                       state_o
);

  localparam int AW = $clog2(N_WALLS) + 3;
  localparam int IW = (N_WALLS > 1) ? $clog2(N_WALLS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_WALLS - 1);

  wall_t          shadow [N_WALLS];
  wall_t          active [N_WALLS];
  state_t         state, state_nx;
  logic [IW-1:0]  copy_idx;
  logic           vb_q;
  logic           vb_rise;
  logic [AW-1:0]  idx_ext;
  logic [IW-1:0]  wr_idx;
  logic           addr_ok;
  logic           wr_ok;
  logic [N_WALLS-1:0] hit;
  logic [23:0]    rgb_nx;
  logic           vis_nx;

  assign idx_ext = address_i >> 3;
  assign wr_idx  = idx_ext[IW-1:0];
  assign addr_ok = (idx_ext < AW'(N_WALLS)) && (address_i[2:0] <= 3'd5);
  assign wr_ok   = MW_i && addr_ok && (state == IDLE);
  assign vb_rise = vblank_i && !vb_q;
  assign busy_o  = (state != IDLE);
  assign state_o = state;

  // Sequencer state register, vblank edge detector, copy index and pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      vb_q     <= 1'b0;
      copy_idx <= '0;
      done_o   <= 1'b0;
      drop_o   <= 1'b0;
    end else begin
      state  <= state_nx;
      vb_q   <= vblank_i;
      done_o <= (state == COPY) && (copy_idx == LAST_IDX);
      drop_o <= MW_i && addr_ok && (state != IDLE);
      if (state == ARMED && vb_rise) copy_idx <= '0;
      else if (state == COPY)        copy_idx <= copy_idx + 1'b1;
    end
  end

  // Next-state logic; a commit in IDLE never consumes a coincident vblank edge.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (commit_i) state_nx = ARMED;
      ARMED:   if (vb_rise) state_nx = COPY;
      COPY:    if (copy_idx == LAST_IDX) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Shadow bank: CPU field writes, accepted only while IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_WALLS; i++) shadow[i] <= reset_wall(i);
    end else if (wr_ok) begin
      case (address_i[2:0])
        FLD_XMIN: shadow[wr_idx].x_min  <= data_i;
        FLD_XMAX: shadow[wr_idx].x_max  <= data_i;
        FLD_YMIN: shadow[wr_idx].y_min  <= data_i;
        FLD_YMAX: shadow[wr_idx].y_max  <= data_i;
        FLD_COL:  shadow[wr_idx].colour <= data_i[23:0];
        FLD_EN:   shadow[wr_idx].en     <= data_i[0];
        default:  ;
      endcase
    end
  end

  // Active bank: one wall copied from shadow per COPY cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_WALLS; i++) active[i] <= reset_wall(i);
    end else if (state == COPY) begin
      active[copy_idx] <= shadow[copy_idx];
    end
  end

  for (genvar g = 0; g < N_WALLS; g++) begin : g_hit
    wall_hit u_hit (
      .wall (active[g]),
      .x    (x_pos_i),
      .y    (y_pos_i),
      .hit  (hit[g])
    );
  end

  // Priority pick: scan high to low so the lowest hit index wins.
  always_comb begin
    rgb_nx = BG_RGB;
    vis_nx = 1'b0;
    for (int i = N_WALLS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        rgb_nx = active[i].colour;
        vis_nx = 1'b1;
      end
    end
  end

  // Registered pixel output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RGB_o     <= BG_RGB;
      visible_o <= 1'b0;
    end else begin
      RGB_o     <= rgb_nx;
      visible_o <= vis_nx;
    end
  end

endmodule

// File: tb/tb_wall_bank_sequencer.sv
// Directed bench for wall_bank_sequencer (N_WALLS = 4, BG_RGB = 0).
module tb_wall_bank_sequencer;
  import walls_pkg::*;

  localparam logic [23:0] BG = 24'h000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        MW_i;
  logic [4:0]  address_i;
  logic [31:0] data_i;
  logic        commit_i;
  logic        vblank_i;
  logic [31:0] x_pos_i;
  logic [31:0] y_pos_i;
  logic [23:0] RGB_o;
  logic        visible_o;
  logic        busy_o;
  logic        done_o;
  logic        drop_o;
  state_t      state_o;

  int n_checks = 0;
  int n_fail   = 0;

  wall_bank_sequencer #(.N_WALLS(4), .BG_RGB(BG)) dut (
    .clk       (clk),
    .rst       (rst),
    .MW_i      (MW_i),
    .address_i (address_i),
    .data_i    (data_i),
    .commit_i  (commit_i),
    .vblank_i  (vblank_i),
    .x_pos_i   (x_pos_i),
    .y_pos_i   (y_pos_i),
    .RGB_o     (RGB_o),
    .visible_o (visible_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .drop_o    (drop_o),
    .state_o   (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic wr(input int idx, input int fld, input logic [31:0] d);
    logic [1:0] i2;
    logic [2:0] f3;
    i2 = idx[1:0];
    f3 = fld[2:0];
    MW_i      = 1'b1;
    address_i = {i2, f3};
    data_i    = d;
    tick();
    MW_i      = 1'b0;
  endtask

  task automatic wr_wall(input int idx, input logic [31:0] xmn, input logic [31:0] xmx,
                         input logic [31:0] ymn, input logic [31:0] ymx,
                         input logic [23:0] col, input logic en);
    wr(idx, 0, xmn);
    wr(idx, 1, xmx);
    wr(idx, 2, ymn);
    wr(idx, 3, ymx);
    wr(idx, 4, {8'h00, col});
    wr(idx, 5, {31'd0, en});
  endtask

  task automatic commit();
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0;
  endtask

  // vblank low then high, then let the 4-cycle copy and done pulse finish
  task automatic vrise_and_copy();
    vblank_i = 1'b0;
    tick();
    vblank_i = 1'b1;
    repeat (6) tick();
    vblank_i = 1'b0;
  endtask

  task automatic pix(input logic [31:0] x, input logic [31:0] y);
    x_pos_i = x;
    y_pos_i = y;
    tick();
  endtask

  initial begin
    rst = 1'b1; MW_i = 1'b0; address_i = '0; data_i = '0;
    commit_i = 1'b0; vblank_i = 1'b0; x_pos_i = 32'd30; y_pos_i = 32'd100;
    repeat (2) tick();
    chk("rst_rgb", {8'h0, RGB_o}, {8'h0, BG});
    chk("rst_vis", {31'd0, visible_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_drop", {31'd0, drop_o}, 32'd0);
    chk("rst_state", {30'd0, state_o}, {30'd0, IDLE});
    rst = 1'b0;
    tick();
`ifdef WALLS_DEFAULT_EN
    chk("post_rst_rgb", {8'h0, RGB_o}, 32'h0015688E);
    chk("post_rst_vis", {31'd0, visible_o}, 32'd1);
`else
    chk("post_rst_rgb", {8'h0, RGB_o}, {8'h0, BG});
    chk("post_rst_vis", {31'd0, visible_o}, 32'd0);
`endif

    // wall 1 into shadow; not visible until committed
    wr_wall(1, 10, 20, 10, 20, 24'hFF0000, 1'b1);
    pix(15, 15);
    chk("shadow_only_rgb", {8'h0, RGB_o}, {8'h0, BG});

    commit();
    chk("armed_state", {30'd0, state_o}, {30'd0, ARMED});
    chk("armed_busy", {31'd0, busy_o}, 32'd1);
    vblank_i = 1'b1;
    tick();
    chk("copy_state", {30'd0, state_o}, {30'd0, COPY});
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("copy_busy", {31'd0, busy_o}, 32'd1);
    end
    chk("copy_no_done", {31'd0, done_o}, 32'd0);
    tick();
    chk("copy_end_busy", {31'd0, busy_o}, 32'd0);
    chk("done_pulse", {31'd0, done_o}, 32'd1);
    tick();
    chk("done_clear", {31'd0, done_o}, 32'd0);
    vblank_i = 1'b0;

    // hit tests against wall 1 (10..20 x 10..20)
    pix(15, 15);
    chk("hit_15_15", {8'h0, RGB_o}, 32'h00FF0000);
    chk("vis_15_15", {31'd0, visible_o}, 32'd1);
    pix(20, 15);
    chk("x_excl_rgb", {8'h0, RGB_o}, {8'h0, BG});
    chk("x_excl_vis", {31'd0, visible_o}, 32'd0);
    pix(10, 10);
    chk("min_incl", {8'h0, RGB_o}, 32'h00FF0000);
    pix(19, 19);
    chk("max_minus1", {8'h0, RGB_o}, 32'h00FF0000);
    pix(15, 20);
    chk("y_excl", {8'h0, RGB_o}, {8'h0, BG});

    // overlap: wall 0 green covers wall 1 region
    wr_wall(0, 10, 30, 10, 30, 24'h00FF00, 1'b1);
    pix(15, 15);
    chk("pre_commit_red", {8'h0, RGB_o}, 32'h00FF0000);
    commit();
    vrise_and_copy();
    pix(15, 15);
    chk("overlap_green", {8'h0, RGB_o}, 32'h0000FF00);
    pix(25, 25);
    chk("wall0_only", {8'h0, RGB_o}, 32'h0000FF00);

    // drop while armed: disable wall 0, arm, then a write that must be lost
    wr(0, 5, 32'd0);
    commit();
    wr(1, 4, 32'h000000FF);
    chk("drop_pulse", {31'd0, drop_o}, 32'd1);
    tick();
    chk("drop_clear", {31'd0, drop_o}, 32'd0);
    chk("drop_still_armed", {30'd0, state_o}, {30'd0, ARMED});
    vrise_and_copy();
    pix(15, 15);
    chk("pre_arm_colour", {8'h0, RGB_o}, 32'h00FF0000);
    pix(25, 25);
    chk("wall0_disabled", {8'h0, RGB_o}, {8'h0, BG});

    // commit coincident with vblank rise: that edge is not used
    wr(1, 4, 32'h0000FFFF);
    tick();
    commit_i = 1'b1;
    vblank_i = 1'b1;
    tick();
    commit_i = 1'b0;
    chk("coinc_armed", {30'd0, state_o}, {30'd0, ARMED});
    repeat (3) tick();
    chk("coinc_still_armed", {30'd0, state_o}, {30'd0, ARMED});
    pix(15, 15);
    chk("coinc_no_copy", {8'h0, RGB_o}, 32'h00FF0000);
    vrise_and_copy();
    pix(15, 15);
    chk("coinc_late_copy", {8'h0, RGB_o}, 32'h0000FFFF);

    // reset at COPY index 1
    wr(1, 4, 32'h00123456);
    commit();
    vblank_i = 1'b1;
    tick();
    tick();
    chk("mid_copy_busy", {31'd0, busy_o}, 32'd1);
    chk("mid_copy_vis", {31'd0, visible_o}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rgb", {8'h0, RGB_o}, {8'h0, BG});
    chk("async_vis", {31'd0, visible_o}, 32'd0);
    chk("async_busy", {31'd0, busy_o}, 32'd0);
    chk("async_state", {30'd0, state_o}, {30'd0, IDLE});
    chk("async_done", {31'd0, done_o}, 32'd0);
    tick();
    rst = 1'b0;
    vblank_i = 1'b0;
    pix(15, 15);
    chk("after_rst_bg", {8'h0, RGB_o}, {8'h0, BG});
    chk("after_rst_vis", {31'd0, visible_o}, 32'd0);
    repeat (5) tick();
    chk("after_rst_no_done", {31'd0, done_o}, 32'd0);
    chk("after_rst_idle", {30'd0, state_o}, {30'd0, IDLE});

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
